conc_stim_player: RTL and testbench

// Synthesizable, parametrised successor to the bench-side opcode replay driver.

---
 rtl/conc_stim_player.sv | 166 ++++++++++++++++
 tb/tb_conc_stim_player.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conc_stim_player.sv
// Stimulus program player: holds a loadable program of {obs, rep, stim} words and
// replays them onto DUT inputs, one word per rep+1 cycles, in one-shot or loop mode.
module conc_stim_player #(
  parameter int STIM_W = 6,
  parameter int REP_W  = 4,
  parameter int DEPTH  = 151,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [STIM_W+REP_W:0]     wr_data,
  input  logic [ADDR_W-1:0]         last_addr,
  input  logic                      loop_en,
  input  logic                      start,
  input  logic                      stop,
  output logic [STIM_W-1:0]         stim_out,
  output logic                      obs_out,
  output logic                      valid,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         pc,
  output logic [CNT_W-1:0]          loop_cnt
);

  localparam int WORD_W = 1 + REP_W + STIM_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic              obs_q, obs_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  loopCnt_q, loopCnt_d;
  logic [REP_W-1:0]  repCnt_q, repCnt_d;

  logic [ADDR_W-1:0] effLast;
  logic [ADDR_W-1:0] fetchAddr;
  logic [WORD_W-1:0] fetchWord;
  logic [CNT_W-1:0]  loopCntInc;

  always_ff @(posedge clock) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A last_addr beyond the memory clamps to the final implemented word.
  assign effLast    = (int'(last_addr) > DEPTH - 1) ? LAST_IDX : last_addr;
  assign loopCntInc = (&loopCnt_q) ? loopCnt_q : loopCnt_q + 1'b1;

  // Only an in-program advance fetches a non-zero address; start and wrap fetch word 0.
  always_comb begin
    fetchAddr = '0;
    if (state_q == RUN && repCnt_q == '0 && pc_q < effLast) begin
      fetchAddr = pc_q + 1'b1;
    end
  end

  assign fetchWord = mem[fetchAddr];

  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    obs_d     = obs_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pc_d      = pc_q;
    loopCnt_d = loopCnt_q;
    repCnt_d  = repCnt_q;
    if (stop) begin
      state_d  = IDLE;
      stim_d   = '0;
      obs_d    = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pc_d     = '0;
      repCnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d   = RUN;
            pc_d      = '0;
            stim_d    = fetchWord[STIM_W-1:0];
            obs_d     = fetchWord[WORD_W-1];
            repCnt_d  = fetchWord[STIM_W +: REP_W];
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            loopCnt_d = '0;
          end
        end
        RUN: begin
          if (repCnt_q != '0) begin
            repCnt_d = repCnt_q - 1'b1;
          end else if (pc_q < effLast) begin
            pc_d     = fetchAddr;
            stim_d   = fetchWord[STIM_W-1:0];
            obs_d    = fetchWord[WORD_W-1];
            repCnt_d = fetchWord[STIM_W +: REP_W];
          end else if (loop_en) begin
            pc_d      = '0;
            stim_d    = fetchWord[STIM_W-1:0];
            obs_d     = fetchWord[WORD_W-1];
            repCnt_d  = fetchWord[STIM_W +: REP_W];
            loopCnt_d = loopCntInc;
          end else begin
            state_d   = DONE;
            loopCnt_d = loopCntInc;
            stim_d    = '0;
            obs_d     = 1'b0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            repCnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      stim_q    <= '0;
      obs_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pc_q      <= '0;
      loopCnt_q <= '0;
      repCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      obs_q     <= obs_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pc_q      <= pc_d;
      loopCnt_q <= loopCnt_d;
      repCnt_q  <= repCnt_d;
    end
  end

  assign stim_out = stim_q;
  assign obs_out  = obs_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pc       = pc_q;
  assign loop_cnt = loopCnt_q;

endmodule

// File: tb/tb_conc_stim_player.sv
// Scoreboard bench for conc_stim_player: expected per-cycle output tuples are
// expanded from a bench copy of the program when playback starts, then drained.
module tb_conc_stim_player;

  localparam int STIM_W = 6;
  localparam int REP_W  = 4;
  localparam int DEPTH  = 151;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;
  localparam int WORD_W = 1 + REP_W + STIM_W;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                wr_en = 1'b0;
  logic [ADDR_W-1:0]   wr_addr = '0;
  logic [WORD_W-1:0]   wr_data = '0;
  logic [ADDR_W-1:0]   last_addr = '0;
  logic                loop_en = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic [STIM_W-1:0]   stim_out;
  logic                obs_out;
  logic                valid;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   pc;
  logic [CNT_W-1:0]    loop_cnt;

  int checks = 0;
  int errors = 0;
  string curTag = "init";
  logic [31:0] expQ[$];
  logic [WORD_W-1:0] progMem [DEPTH];

  conc_stim_player #(
    .STIM_W(STIM_W), .REP_W(REP_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_addr(last_addr), .loop_en(loop_en), .start(start), .stop(stop),
    .stim_out(stim_out), .obs_out(obs_out), .valid(valid), .busy(busy), .done(done),
    .pc(pc), .loop_cnt(loop_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] sat(input int lc);
    return (lc > 15) ? 4'hF : 4'(lc);
  endfunction

  function automatic logic [31:0] pack(input logic b, input logic d, input logic v,
                                       input logic o, input logic [5:0] s,
                                       input logic [7:0] p, input logic [3:0] lc);
    return {10'b0, b, d, v, o, s, p, lc};
  endfunction

  function automatic logic [31:0] packOut();
    return pack(busy, done, valid, obs_out, stim_out, pc, loop_cnt);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge.
  task automatic loadWord(input int addr, input logic o, input logic [3:0] r, input logic [5:0] s);
    wr_en   = 1'b1;
    wr_addr = 8'(addr);
    wr_data = {o, r, s};
    if (addr < DEPTH) progMem[addr] = {o, r, s};
    @(posedge clock);
    #1 wr_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic pushPass(input int lastIdx, input int lc);
    logic [WORD_W-1:0] w;
    for (int a = 0; a <= lastIdx; a++) begin
      w = progMem[a];
      for (int r = 0; r <= int'(w[9:6]); r++)
        expQ.push_back(pack(1'b1, 1'b0, 1'b1, w[10], w[5:0], 8'(a), sat(lc)));
    end
  endtask

  task automatic pushDone(input int p, input int lc);
    expQ.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 6'h0, 8'(p), sat(lc)));
  endtask

  task automatic pushIdle(input int lc);
    expQ.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 8'h0, sat(lc)));
  endtask

  task automatic drainN(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (expQ.size() == 0) checkOutput({curTag, "_underflow"}, 32'h1, 32'h0);
      else checkOutput(curTag, packOut(), expQ.pop_front());
    end
  endtask

  task automatic drainAll();
    while (expQ.size() > 0) begin
      @(negedge clock);
      checkOutput(curTag, packOut(), expQ.pop_front());
    end
  endtask

  // Control pulses are raised at a negedge and dropped just after the next posedge.
  task automatic applyStimulus(input logic doStart, input logic doStop);
    start = doStart;
    stop  = doStop;
    @(posedge clock);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    curTag = "reset_state";
    checkOutput(curTag, packOut(), pack(0, 0, 0, 0, 6'h0, 8'h0, 4'h0));
    reset = 1'b1;
    @(negedge clock);

    // One-shot program
    loadWord(0, 1'b0, 4'd0, 6'h01);
    loadWord(1, 1'b1, 4'd2, 6'h02);
    loadWord(2, 1'b0, 4'd0, 6'h3F);
    last_addr = 8'd2;
    loop_en   = 1'b0;
    curTag = "oneshot";
    applyStimulus(1'b1, 1'b0);
    pushPass(2, 0);
    pushDone(2, 1);
    pushDone(2, 1);
    drainAll();

    // Loop mode restarted from DONE, then stopped with loop_cnt kept
    loop_en = 1'b1;
    curTag = "loop";
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) pushPass(2, k);
    drainAll();
    curTag = "loop_stop";
    applyStimulus(1'b0, 1'b1);
    pushIdle(3);
    drainAll();

    // Single-word loop drives loop_cnt into saturation
    last_addr = 8'd0;
    curTag = "saturate";
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 20; k++) pushPass(0, k);
    drainAll();
    applyStimulus(1'b0, 1'b1);
    pushIdle(15);
    drainAll();

    // Stop beats start; mid-run stop; replay from word 0
    curTag = "start_stop";
    applyStimulus(1'b1, 1'b1);
    pushIdle(15);
    pushIdle(15);
    drainAll();
    last_addr = 8'd2;
    loop_en   = 1'b0;
    curTag = "mid_stop";
    applyStimulus(1'b1, 1'b0);
    pushPass(2, 0);
    drainN(3);
    expQ.delete();
    applyStimulus(1'b0, 1'b1);
    pushIdle(0);
    drainAll();
    curTag = "replay";
    applyStimulus(1'b1, 1'b0);
    pushPass(2, 0);
    pushDone(2, 1);
    drainAll();

    // Full memory, out-of-range writes ignored, last_addr clamped to DEPTH-1
    for (int i = 0; i < DEPTH; i++)
      loadWord(i, i[0], (i % 7 == 0) ? 4'd1 : 4'd0, 6'(i ^ (i >> 6)));
    loadWord(DEPTH, 1'b1, 4'd15, 6'h2A);
    loadWord(255, 1'b1, 4'd15, 6'h15);
    last_addr = 8'd255;
    curTag = "bounds";
    applyStimulus(1'b1, 1'b0);
    pushPass(DEPTH - 1, 0);
    pushDone(DEPTH - 1, 1);
    drainAll();

    // Live write to the held word shows up only on the next pass
    loadWord(0, 1'b0, 4'd0, 6'h01);
    loadWord(1, 1'b1, 4'd2, 6'h02);
    loadWord(2, 1'b0, 4'd0, 6'h3F);
    last_addr = 8'd2;
    loop_en   = 1'b1;
    curTag = "live_write";
    applyStimulus(1'b1, 1'b0);
    pushPass(2, 0);
    drainN(2);
    wr_en   = 1'b1;
    wr_addr = 8'd1;
    wr_data = {1'b0, 4'd0, 6'h2A};
    progMem[1] = {1'b0, 4'd0, 6'h2A};
    @(posedge clock);
    #1 wr_en = 1'b0;
    pushPass(2, 1);
    drainAll();
    applyStimulus(1'b0, 1'b1);
    pushIdle(1);
    drainAll();

    // Asynchronous reset between edges while running
    curTag = "async_reset";
    applyStimulus(1'b1, 1'b0);
    pushPass(2, 0);
    drainN(3);
    expQ.delete();
    #2 reset = 1'b0;
    #1 checkOutput(curTag, packOut(), pack(0, 0, 0, 0, 6'h0, 8'h0, 4'h0));
    @(negedge clock);
    reset = 1'b1;
    curTag = "after_reset";
    pushIdle(0);
    pushIdle(0);
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
